// File: rtl/game_flow_sm.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_sm
//  Description : Top-level Bomber Man game flow controller. Sequences the
//                main menu, mode select, controls, level banner, gameplay,
//                pause, death delay, game-over and game-won screens for any
//                number of levels and play modes. Drives a screen-select code
//                to the external RGB mux.
//  Revision    : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i              system clock (single domain)
//    resetN_i           synchronous active-low reset
//    enter_key_i        raw key levels, already synchronous to clk_i
//    up_key_i / down_key_i / pause_key_i
//    one_sec_pulse_i    single-cycle 1 Hz tick
//    timer_ended_i      level timer expired (level)
//    player_died_i      last life lost (level)
//    level_cleared_i    level exit reached (level)
//    screen_sel_o       0 main,1 mode,2 controls,3 banner,4 play,5 pause,
//                       6 game over,7 game won
//    game_on_o          gameplay logic enabled
//    paused_o           high in PAUSE
//    mode_sel_o         selected mode (0 = single player)
//    level_sel_o        current level, 1-based
//    game_over_type_o   0 timeout, 1 lives, 2 multi-player end
//    score_reset_o      single-cycle pulse on leaving the main menu
//    lives_reset_o      single-cycle pulse on returning to the main menu
//    play_menu_music_o  high on the menu screens
// ============================================================================
module game_flow_sm #(
    parameter  int NUM_LEVELS       = 3,
    parameter  int NUM_MODES        = 2,
    parameter  int LEVEL_DSP_SEC    = 3,
    parameter  int GAMEOVER_DLY_SEC = 3,
    localparam int LVL_W            = $clog2(NUM_LEVELS + 1),
    localparam int MODE_W           = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int SEC_MAX          = (LEVEL_DSP_SEC > GAMEOVER_DLY_SEC) ?
                                      LEVEL_DSP_SEC : GAMEOVER_DLY_SEC,
    localparam int SEC_W            = $clog2(SEC_MAX + 1)
) (
    input  logic              clk_i,
    input  logic              resetN_i,
    input  logic              enter_key_i,
    input  logic              up_key_i,
    input  logic              down_key_i,
    input  logic              pause_key_i,
    input  logic              one_sec_pulse_i,
    input  logic              timer_ended_i,
    input  logic              player_died_i,
    input  logic              level_cleared_i,
    output logic [3:0]        screen_sel_o,
    output logic              game_on_o,
    output logic              paused_o,
    output logic [MODE_W-1:0] mode_sel_o,
    output logic [LVL_W-1:0]  level_sel_o,
    output logic [1:0]        game_over_type_o,
    output logic              score_reset_o,
    output logic              lives_reset_o,
    output logic              play_menu_music_o
);

    // State encoding
    localparam logic [3:0] c_ST_MAIN      = 4'd0;
    localparam logic [3:0] c_ST_MODE_SEL  = 4'd1;
    localparam logic [3:0] c_ST_CONTROLS  = 4'd2;
    localparam logic [3:0] c_ST_LEVEL_DSP = 4'd3;
    localparam logic [3:0] c_ST_GAMEPLAY  = 4'd4;
    localparam logic [3:0] c_ST_PAUSE     = 4'd5;
    localparam logic [3:0] c_ST_DYING     = 4'd6;
    localparam logic [3:0] c_ST_GAMEOVER  = 4'd7;
    localparam logic [3:0] c_ST_WON       = 4'd8;

    // Game-over reasons
    localparam logic [1:0] c_GO_TIMEOUT = 2'd0;
    localparam logic [1:0] c_GO_LIVES   = 2'd1;
    localparam logic [1:0] c_GO_MULTI   = 2'd2;

    localparam logic [LVL_W-1:0]  c_LEVEL_FIRST = LVL_W'(1);
    localparam logic [LVL_W-1:0]  c_LEVEL_LAST  = LVL_W'(NUM_LEVELS);
    localparam logic [MODE_W-1:0] c_MODE_MAX    = MODE_W'(NUM_MODES - 1);
    localparam logic [SEC_W-1:0]  c_BANNER_SEC  = SEC_W'(LEVEL_DSP_SEC);
    localparam logic [SEC_W-1:0]  c_DYING_SEC   = SEC_W'(GAMEOVER_DLY_SEC);

    logic [3:0]        state_q,       state_d;
    logic [SEC_W-1:0]  sec_cnt_q,     sec_cnt_d;
    logic              game_on_q,     game_on_d;
    logic              paused_q,      paused_d;
    logic [MODE_W-1:0] mode_sel_q,    mode_sel_d;
    logic [LVL_W-1:0]  level_sel_q,   level_sel_d;
    logic [1:0]        over_type_q,   over_type_d;
    logic              score_reset_q, score_reset_d;
    logic              lives_reset_q, lives_reset_d;

    // Previous key levels, bit order {pause, down, up, enter}. Reset to all
    // ones so a key already held during reset cannot produce an edge.
    logic [3:0] key_prev_q;
    logic [3:0] w_keys;
    logic [3:0] w_key_edge;
    logic       w_enter_edge;
    logic       w_up_edge;
    logic       w_down_edge;
    logic       w_pause_edge;
    logic       w_multi;

    assign w_keys       = {pause_key_i, down_key_i, up_key_i, enter_key_i};
    assign w_key_edge   = w_keys & ~key_prev_q;
    assign w_enter_edge = w_key_edge[0];
    assign w_up_edge    = w_key_edge[1];
    assign w_down_edge  = w_key_edge[2];
    assign w_pause_edge = w_key_edge[3];
    assign w_multi      = (mode_sel_q != '0);

    // ------------------------------------------------------------------------
    // State / output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!resetN_i) begin
            state_q       <= c_ST_MAIN;
            sec_cnt_q     <= '0;
            game_on_q     <= 1'b0;
            paused_q      <= 1'b0;
            mode_sel_q    <= '0;
            level_sel_q   <= c_LEVEL_FIRST;
            over_type_q   <= c_GO_TIMEOUT;
            score_reset_q <= 1'b0;
            lives_reset_q <= 1'b0;
            key_prev_q    <= 4'b1111;
        end else begin
            state_q       <= state_d;
            sec_cnt_q     <= sec_cnt_d;
            game_on_q     <= game_on_d;
            paused_q      <= paused_d;
            mode_sel_q    <= mode_sel_d;
            level_sel_q   <= level_sel_d;
            over_type_q   <= over_type_d;
            score_reset_q <= score_reset_d;
            lives_reset_q <= lives_reset_d;
            key_prev_q    <= w_keys;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        sec_cnt_d     = sec_cnt_q;
        game_on_d     = game_on_q;
        paused_d      = paused_q;
        mode_sel_d    = mode_sel_q;
        level_sel_d   = level_sel_q;
        over_type_d   = over_type_q;
        score_reset_d = 1'b0;
        lives_reset_d = 1'b0;

        case (state_q)
            c_ST_MAIN: begin
                if (w_enter_edge) begin
                    state_d       = c_ST_MODE_SEL;
                    score_reset_d = 1'b1;
                end
            end

            c_ST_MODE_SEL: begin
                // Opposing edges in the same cycle cancel out.
                if (w_down_edge && !w_up_edge && (mode_sel_q != c_MODE_MAX)) begin
                    mode_sel_d = mode_sel_q + 1'b1;
                end else if (w_up_edge && !w_down_edge && (mode_sel_q != '0)) begin
                    mode_sel_d = mode_sel_q - 1'b1;
                end
                if (w_enter_edge) begin
                    state_d = c_ST_CONTROLS;
                end
            end

            c_ST_CONTROLS: begin
                if (w_enter_edge) begin
                    if (w_multi) begin
                        state_d   = c_ST_GAMEPLAY;
                        game_on_d = 1'b1;
                    end else begin
                        state_d   = c_ST_LEVEL_DSP;
                        sec_cnt_d = c_BANNER_SEC;
                    end
                end
            end

            c_ST_LEVEL_DSP: begin
                // Leaving on the cycle after the count hits zero gives exactly
                // N pulses plus one clock on screen.
                if (sec_cnt_q == '0) begin
                    state_d   = c_ST_GAMEPLAY;
                    game_on_d = 1'b1;
                end else if (one_sec_pulse_i) begin
                    sec_cnt_d = sec_cnt_q - 1'b1;
                end
            end

            c_ST_GAMEPLAY: begin
                if (player_died_i) begin
                    state_d     = c_ST_DYING;
                    sec_cnt_d   = c_DYING_SEC;
                    over_type_d = w_multi ? c_GO_MULTI : c_GO_LIVES;
                end else if (timer_ended_i) begin
                    state_d     = c_ST_DYING;
                    sec_cnt_d   = c_DYING_SEC;
                    over_type_d = w_multi ? c_GO_MULTI : c_GO_TIMEOUT;
                end else if (level_cleared_i && !w_multi) begin
                    game_on_d = 1'b0;
                    if (level_sel_q < c_LEVEL_LAST) begin
                        level_sel_d = level_sel_q + 1'b1;
                        state_d     = c_ST_LEVEL_DSP;
                        sec_cnt_d   = c_BANNER_SEC;
                    end else begin
                        state_d = c_ST_WON;
                    end
                end else if (w_pause_edge) begin
                    state_d   = c_ST_PAUSE;
                    game_on_d = 1'b0;
                    paused_d  = 1'b1;
                end
            end

            c_ST_PAUSE: begin
                // Quitting to the menu takes precedence over resuming.
                if (w_enter_edge) begin
                    state_d       = c_ST_MAIN;
                    lives_reset_d = 1'b1;
                end else if (w_pause_edge) begin
                    state_d   = c_ST_GAMEPLAY;
                    game_on_d = 1'b1;
                    paused_d  = 1'b0;
                end
            end

            c_ST_DYING: begin
                // game_on stays high so the death animation keeps running.
                if (sec_cnt_q == '0) begin
                    state_d   = c_ST_GAMEOVER;
                    game_on_d = 1'b0;
                end else if (one_sec_pulse_i) begin
                    sec_cnt_d = sec_cnt_q - 1'b1;
                end
            end

            c_ST_GAMEOVER, c_ST_WON: begin
                if (w_enter_edge) begin
                    state_d       = c_ST_MAIN;
                    lives_reset_d = 1'b1;
                end
            end

            default: begin
                state_d = c_ST_MAIN;
            end
        endcase

        // Being in, or entering, the main menu re-arms a fresh run.
        if (state_d == c_ST_MAIN) begin
            level_sel_d = c_LEVEL_FIRST;
            mode_sel_d  = '0;
            game_on_d   = 1'b0;
            paused_d    = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        screen_sel_o      = 4'd0;
        play_menu_music_o = 1'b0;
        case (state_q)
            c_ST_MAIN:      begin screen_sel_o = 4'd0; play_menu_music_o = 1'b1; end
            c_ST_MODE_SEL:  begin screen_sel_o = 4'd1; play_menu_music_o = 1'b1; end
            c_ST_CONTROLS:  begin screen_sel_o = 4'd2; play_menu_music_o = 1'b1; end
            c_ST_LEVEL_DSP: screen_sel_o = 4'd3;
            c_ST_GAMEPLAY:  screen_sel_o = 4'd4;
            c_ST_PAUSE:     screen_sel_o = 4'd5;
            c_ST_DYING:     screen_sel_o = 4'd4;
            c_ST_GAMEOVER:  screen_sel_o = 4'd6;
            c_ST_WON:       screen_sel_o = 4'd7;
            default:        screen_sel_o = 4'd0;
        endcase

        game_on_o        = game_on_q;
        paused_o         = paused_q;
        mode_sel_o       = mode_sel_q;
        level_sel_o      = level_sel_q;
        game_over_type_o = over_type_q;
        score_reset_o    = score_reset_q;
        lives_reset_o    = lives_reset_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_game_flow_sm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_flow_sm
//  Description : Self-checking bench for game_flow_sm: a vector table for the
//                menu/mode path, directed multi-cycle sequences, and random
//                stimulus compared against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_sm;

    localparam int NL = 3;
    localparam int NM = 3;
    localparam int LD = 3;
    localparam int GD = 3;

    // {ent, up, dn, pau, sec, tmr, die, clr}
    localparam logic [7:0] K_IDLE = 8'h00;
    localparam logic [7:0] K_ENT  = 8'h80;
    localparam logic [7:0] K_DN   = 8'h20;
    localparam logic [7:0] K_PAU  = 8'h10;
    localparam logic [7:0] K_SEC  = 8'h08;
    localparam logic [7:0] K_TMR  = 8'h04;
    localparam logic [7:0] K_DIE  = 8'h02;
    localparam logic [7:0] K_CLR  = 8'h01;

    typedef struct packed {
        logic rst_n; logic ent; logic up; logic dn; logic pau;
        logic sec;   logic tmr; logic die; logic clr;
    } in_t;

    typedef struct packed {
        logic [3:0] scr; logic gon; logic pd; logic [1:0] mode;
        logic [1:0] lvl; logic [1:0] typ; logic srst; logic lrst; logic mus;
    } outs_t;

    typedef struct packed { in_t i; outs_t o; } vec_t;

    typedef enum int { M_MAIN, M_MODE, M_CTRL, M_BANNER, M_PLAY,
                       M_PAUSE, M_DYING, M_OVER, M_WON } mstate_t;

    localparam outs_t RESET_OUTS = 15'b0000_0_0_00_01_00_0_0_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ent, up, dn, pau, sec, tmr, die, clr;
    logic [3:0] scr;
    logic gon, pd, srst, lrst, mus;
    logic [1:0] mode, lvl, typ;

    int n_chk = 0;
    int n_err = 0;

    game_flow_sm #(
        .NUM_LEVELS(NL), .NUM_MODES(NM),
        .LEVEL_DSP_SEC(LD), .GAMEOVER_DLY_SEC(GD)
    ) dut (
        .clk_i(clk), .resetN_i(rst_n),
        .enter_key_i(ent), .up_key_i(up), .down_key_i(dn), .pause_key_i(pau),
        .one_sec_pulse_i(sec), .timer_ended_i(tmr),
        .player_died_i(die), .level_cleared_i(clr),
        .screen_sel_o(scr), .game_on_o(gon), .paused_o(pd),
        .mode_sel_o(mode), .level_sel_o(lvl), .game_over_type_o(typ),
        .score_reset_o(srst), .lives_reset_o(lrst), .play_menu_music_o(mus)
    );

    // ------------------------------------------------------------------------
    // Reference model: game rules with plain integers and a named phase
    // ------------------------------------------------------------------------
    mstate_t m_st;
    int m_mode, m_level, m_type, m_secs;
    bit m_gon, m_pd, m_srst, m_lrst;
    bit m_prev[4];

    task automatic model_reset();
        m_st = M_MAIN; m_mode = 0; m_level = 1; m_type = 0; m_secs = 0;
        m_gon = 0; m_pd = 0; m_srst = 0; m_lrst = 0;
        foreach (m_prev[k]) m_prev[k] = 1'b1;
    endtask

    task automatic model_step(input in_t v);
        bit e_ent, e_up, e_dn, e_pau;
        e_ent = v.ent && !m_prev[0];
        e_up  = v.up  && !m_prev[1];
        e_dn  = v.dn  && !m_prev[2];
        e_pau = v.pau && !m_prev[3];
        m_prev[0] = v.ent; m_prev[1] = v.up; m_prev[2] = v.dn; m_prev[3] = v.pau;
        m_srst = 0; m_lrst = 0;
        if (!v.rst_n) begin
            model_reset();
            return;
        end
        case (m_st)
            M_MAIN: if (e_ent) begin m_st = M_MODE; m_srst = 1; end
            M_MODE: begin
                if (e_dn && !e_up && m_mode < NM - 1) m_mode++;
                if (e_up && !e_dn && m_mode > 0)      m_mode--;
                if (e_ent) m_st = M_CTRL;
            end
            M_CTRL: if (e_ent) begin
                if (m_mode == 0) begin m_st = M_BANNER; m_secs = LD; end
                else begin m_st = M_PLAY; m_gon = 1; end
            end
            M_BANNER, M_DYING: begin
                if (m_secs == 0) begin
                    if (m_st == M_BANNER) begin m_st = M_PLAY; m_gon = 1; end
                    else begin m_st = M_OVER; m_gon = 0; end
                end else if (v.sec) m_secs--;
            end
            M_PLAY: begin
                if (v.die || v.tmr) begin
                    m_st = M_DYING; m_secs = GD;
                    m_type = (m_mode != 0) ? 2 : (v.die ? 1 : 0);
                end else if (v.clr && m_mode == 0) begin
                    m_gon = 0;
                    if (m_level < NL) begin m_level++; m_st = M_BANNER; m_secs = LD; end
                    else m_st = M_WON;
                end else if (e_pau) begin
                    m_st = M_PAUSE; m_gon = 0; m_pd = 1;
                end
            end
            M_PAUSE: begin
                if (e_ent) begin m_st = M_MAIN; m_lrst = 1; end
                else if (e_pau) begin m_st = M_PLAY; m_gon = 1; m_pd = 0; end
            end
            M_OVER, M_WON: if (e_ent) begin m_st = M_MAIN; m_lrst = 1; end
            default: m_st = M_MAIN;
        endcase
        if (m_st == M_MAIN) begin
            m_level = 1; m_mode = 0; m_gon = 0; m_pd = 0;
        end
    endtask

    function automatic outs_t model_outs();
        outs_t o;
        case (m_st)
            M_MAIN:   o.scr = 4'd0;
            M_MODE:   o.scr = 4'd1;
            M_CTRL:   o.scr = 4'd2;
            M_BANNER: o.scr = 4'd3;
            M_PAUSE:  o.scr = 4'd5;
            M_OVER:   o.scr = 4'd6;
            M_WON:    o.scr = 4'd7;
            default:  o.scr = 4'd4;   // gameplay and dying share a screen
        endcase
        o.gon  = m_gon;
        o.pd   = m_pd;
        o.mode = 2'(m_mode);
        o.lvl  = 2'(m_level);
        o.typ  = 2'(m_type);
        o.srst = m_srst;
        o.lrst = m_lrst;
        o.mus  = (m_st == M_MAIN || m_st == M_MODE || m_st == M_CTRL);
        return o;
    endfunction

    // ------------------------------------------------------------------------
    // Drive / check helpers
    // ------------------------------------------------------------------------
    function automatic outs_t actual();
        return outs_t'({scr, gon, pd, mode, lvl, typ, srst, lrst, mus});
    endfunction

    task automatic tick(input in_t v);
        @(negedge clk);
        {rst_n, ent, up, dn, pau, sec, tmr, die, clr} = v;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    task automatic tk(input logic [7:0] k);
        tick(in_t'({1'b1, k}));
    endtask

    task automatic chk_outs(input string name, input outs_t got, input outs_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got scr/gon/pd/mode/lvl/typ/srst/lrst/mus=%b required=%b",
                     name, got, exp);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Main menu to gameplay in single-player mode.
    task automatic to_gameplay0();
        tk(K_ENT); tk(K_IDLE); tk(K_ENT); tk(K_IDLE); tk(K_ENT);
        repeat (LD) tk(K_SEC);
        tk(K_IDLE);
    endtask

    vec_t tbl[20];

    initial begin
        // rst_ent_up_dn_pau_sec_tmr_die_clr  |  scr_gon_pd_mode_lvl_typ_srst_lrst_mus
        tbl[0]  = {9'b0_1_0_0_0_0_0_0_0, 15'b0000_0_0_00_01_00_0_0_1};
        tbl[1]  = {9'b1_1_0_0_0_0_0_0_0, 15'b0000_0_0_00_01_00_0_0_1};
        tbl[2]  = {9'b1_0_0_0_0_0_0_0_0, 15'b0000_0_0_00_01_00_0_0_1};
        tbl[3]  = {9'b1_1_0_0_0_0_0_0_0, 15'b0001_0_0_00_01_00_1_0_1};
        tbl[4]  = {9'b1_0_0_0_0_0_0_0_0, 15'b0001_0_0_00_01_00_0_0_1};
        tbl[5]  = {9'b1_0_0_1_0_0_0_0_0, 15'b0001_0_0_01_01_00_0_0_1};
        tbl[6]  = {9'b1_0_0_0_0_0_0_0_0, 15'b0001_0_0_01_01_00_0_0_1};
        tbl[7]  = {9'b1_0_0_1_0_0_0_0_0, 15'b0001_0_0_10_01_00_0_0_1};
        tbl[8]  = {9'b1_0_0_0_0_0_0_0_0, 15'b0001_0_0_10_01_00_0_0_1};
        tbl[9]  = {9'b1_0_0_1_0_0_0_0_0, 15'b0001_0_0_10_01_00_0_0_1};
        tbl[10] = {9'b1_0_0_0_0_0_0_0_0, 15'b0001_0_0_10_01_00_0_0_1};
        tbl[11] = {9'b1_0_1_1_0_0_0_0_0, 15'b0001_0_0_10_01_00_0_0_1};
        tbl[12] = {9'b1_0_0_0_0_0_0_0_0, 15'b0001_0_0_10_01_00_0_0_1};
        tbl[13] = {9'b1_0_1_0_0_0_0_0_0, 15'b0001_0_0_01_01_00_0_0_1};
        tbl[14] = {9'b1_0_0_0_0_0_0_0_0, 15'b0001_0_0_01_01_00_0_0_1};
        tbl[15] = {9'b1_0_1_0_0_0_0_0_0, 15'b0001_0_0_00_01_00_0_0_1};
        tbl[16] = {9'b1_0_0_0_0_0_0_0_0, 15'b0001_0_0_00_01_00_0_0_1};
        tbl[17] = {9'b1_1_0_0_0_0_0_0_0, 15'b0010_0_0_00_01_00_0_0_1};
        tbl[18] = {9'b1_0_0_0_0_0_0_0_0, 15'b0010_0_0_00_01_00_0_0_1};
        tbl[19] = {9'b1_1_0_0_0_0_0_0_0, 15'b0011_0_0_00_01_00_0_0_0};

        {rst_n, ent, up, dn, pau, sec, tmr, die, clr} = '0;
        model_reset();

        // Menu path: reset with enter held, mode selection
        for (int i = 0; i < 20; i++) begin
            tick(tbl[i].i);
            chk_outs($sformatf("vec%0d", i), actual(), tbl[i].o);
        end

        // Level banners through to WON
        tk(K_IDLE);
        chk("banner1_hold", int'(scr), 3);
        tk(K_SEC); tk(K_IDLE); tk(K_SEC); tk(K_IDLE); tk(K_SEC);
        chk("banner1_last", int'(scr), 3);
        tk(K_IDLE);
        chk("banner1_exit", int'(scr), 4);
        chk("banner1_gon", int'(gon), 1);
        for (int lv = 2; lv <= NL; lv++) begin
            tk(K_CLR);
            chk("clr_scr", int'(scr), 3);
            chk("clr_gon", int'(gon), 0);
            chk("clr_lvl", int'(lvl), lv);
            repeat (LD) tk(K_SEC);
            chk("banner_last", int'(scr), 3);
            tk(K_IDLE);
            chk("banner_exit", int'(scr), 4);
        end
        tk(K_CLR);
        chk("won_scr", int'(scr), 7);
        chk("won_gon", int'(gon), 0);
        chk("won_lvl", int'(lvl), 3);
        tk(K_IDLE);
        tk(K_ENT);
        chk_outs("won_to_main", actual(), 15'b0000_0_0_00_01_00_0_1_1);
        tk(K_IDLE);
        chk("lrst_one_cycle", int'(lrst), 0);

        // Death has priority over timeout; dying keeps game_on high
        to_gameplay0();
        tk(K_DIE | K_TMR);
        chk("dying_scr", int'(scr), 4);
        chk("dying_gon", int'(gon), 1);
        chk("dying_type", int'(typ), 1);
        tk(K_SEC); tk(K_IDLE); tk(K_SEC); tk(K_IDLE); tk(K_SEC);
        chk("dying_last_gon", int'(gon), 1);
        tk(K_IDLE);
        chk("over_scr", int'(scr), 6);
        chk("over_gon", int'(gon), 0);
        tk(K_ENT);
        chk_outs("over_to_main", actual(), 15'b0000_0_0_00_01_01_0_1_1);
        tk(K_IDLE);

        // Pause, resume, then quit with pause and enter together
        to_gameplay0();
        tk(K_PAU);
        chk_outs("pause", actual(), 15'b0101_0_1_00_01_01_0_0_0);
        tk(K_IDLE);
        tk(K_PAU);
        chk_outs("resume", actual(), 15'b0100_1_0_00_01_01_0_0_0);
        tk(K_IDLE);
        tk(K_PAU);
        tk(K_IDLE);
        tk(K_ENT | K_PAU);
        chk_outs("pause_quit", actual(), 15'b0000_0_0_00_01_01_0_1_1);
        tk(K_IDLE);

        // Multi-player: no banner, level_cleared ignored, reset mid-dying
        tk(K_ENT);
        chk("mp_srst", int'(srst), 1);
        tk(K_IDLE);
        tk(K_DN);
        tk(K_IDLE);
        tk(K_ENT);
        tk(K_IDLE);
        tk(K_ENT);
        chk_outs("mp_play", actual(), 15'b0100_1_0_01_01_01_0_0_0);
        tk(K_CLR);
        chk_outs("mp_clr_ignored", actual(), 15'b0100_1_0_01_01_01_0_0_0);
        tk(K_TMR);
        chk("mp_type", int'(typ), 2);
        tk(K_SEC);
        tk(K_IDLE);
        tick(in_t'(9'b0));
        chk_outs("reset_mid_dying", actual(), RESET_OUTS);

        // Random stimulus against the reference model
        for (int n = 0; n < 5000; n++) begin
            in_t v;
            v.rst_n = ($urandom_range(0, 299) != 0);
            v.ent   = ($urandom_range(0, 3) == 0);
            v.up    = ($urandom_range(0, 3) == 0);
            v.dn    = ($urandom_range(0, 3) == 0);
            v.pau   = ($urandom_range(0, 5) == 0);
            v.sec   = ($urandom_range(0, 2) == 0);
            v.tmr   = ($urandom_range(0, 59) == 0);
            v.die   = ($urandom_range(0, 59) == 0);
            v.clr   = ($urandom_range(0, 19) == 0);
            tick(v);
            chk_outs($sformatf("rand%0d", n), actual(), model_outs());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
